// File: rtl/muldiv_iter_unit.sv
// muldiv_iter_unit
//   Multi-cycle multiply/divide unit that owns the architectural HI/LO pair.
//   Multiplication is shift-add and division is restoring. Both run on
//   operand magnitudes, and the signs are applied in the FIX state.
//   UNROLL result bits are produced per CALC cycle.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start, op     begin operation (IDLE only); op: 00 mult 01 multu 10 div 11 divu
//   a, b          rs / rt operands
//   flush         cancel an in-flight operation (also blocks a same-cycle start)
//   mthi, mtlo    write wdata to HI / LO while IDLE
//   wdata         mthi/mtlo data
//   busy          operation in flight
//   done          one-cycle pulse: HI/LO hold the new result
//   div_zero      one-cycle pulse with done for a divide by zero
//   hi, lo        HI / LO registers
module muldiv_iter_unit #(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int N     = WIDTH / UNROLL;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic               dz_q, dz_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Multiply: {partial sum, remaining multiplier bits}. Divide: low half
    // shifts the dividend out while the quotient bits shift in.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    // Multiplicand for multiply, divisor for divide
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, dzo_q, dzo_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] acc_t, prod;
    logic [WIDTH:0]     rem_t;

    // One shift-add step. The carry out of the add lands in the top bit.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0]   mcand);
        logic [WIDTH:0] sum;
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        return {sum, acc[WIDTH-1:1]};
    endfunction

    // One restoring-division step. Returns {remainder, shifted quotient}.
    function automatic logic [2*WIDTH:0] div_step(input logic [WIDTH:0]   rem,
                                                  input logic [WIDTH-1:0] quo,
                                                  input logic [WIDTH-1:0] dvs);
        logic [WIDTH:0] sh;
        sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
        if (sh >= {1'b0, dvs})
            return {sh - {1'b0, dvs}, quo[WIDTH-2:0], 1'b1};
        else
            return {sh, quo[WIDTH-2:0], 1'b0};
    endfunction

    // op[0]==0 selects the signed forms
    assign abs_a = (a[WIDTH-1] && !op[0]) ? -a : a;
    assign abs_b = (b[WIDTH-1] && !op[0]) ? -b : b;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        dz_d     = dz_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opd_d    = opd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dzo_d    = 1'b0;
        acc_t    = acc_q;
        rem_t    = rem_q;
        prod     = '0;

        case (state_q)
            S_IDLE: begin
                if (mthi) hi_d = wdata;
                if (mtlo) lo_d = wdata;
                if (start && !flush) begin
                    op_d     = op;
                    sign_a_d = a[WIDTH-1] & ~op[0];
                    sign_b_d = b[WIDTH-1] & ~op[0];
                    cnt_d    = CNT_W'(N);
                    rem_d    = '0;
                    dz_d     = op[1] && (b == '0);
                    if (op[1]) begin
                        acc_d = {{WIDTH{1'b0}}, abs_a};
                        opd_d = abs_b;
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, abs_b};
                        opd_d = abs_a;
                    end
                    // A zero divisor skips the iteration entirely
                    state_d = (op[1] && (b == '0)) ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                for (int i = 0; i < UNROLL; i++) begin
                    if (op_q[1])
                        {rem_t, acc_t[WIDTH-1:0]} = div_step(rem_t, acc_t[WIDTH-1:0], opd_q);
                    else
                        acc_t = mul_step(acc_t, opd_q);
                end
                acc_d = acc_t;
                rem_d = rem_t;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
                if (flush) state_d = S_IDLE;
            end
            S_FIX: begin
                state_d = S_IDLE;
                // flush cancels the commit and both pulses
                if (!flush) begin
                    done_d = 1'b1;
                    dzo_d  = dz_q;
                    if (!dz_q) begin
                        if (op_q[1]) begin
                            lo_d = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                            hi_d = sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                        end else begin
                            prod = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
                            hi_d = prod[2*WIDTH-1:WIDTH];
                            lo_d = prod[WIDTH-1:0];
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dz_q     <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            opd_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dzo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            dz_q     <= dz_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opd_q    <= opd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dzo_q    <= dzo_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign div_zero = dzo_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
